// File: rtl/fir_coef_bank.sv
// Double-buffered FIR coefficient bank behind a Wishbone slave; a commit copies shadow to active on fir_ce.
// Define FIR_COEF_SYM_EN for symmetric mode: only taps 0..(NTAPS-1)/2 addressable, writes mirrored.
module fir_coef_bank #(
    parameter int NTAPS = 33,
    parameter int CW    = 16,
    parameter int DW    = 16,
    parameter int AW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         wb_adr,
    input  logic [DW-1:0]         wb_wr_dat,
    output logic [DW-1:0]         wb_rd_dat,
    input  logic                  wb_we,
    input  logic [DW/8-1:0]       wb_sel,
    input  logic                  wb_stb,
    input  logic                  wb_cyc,
    output logic                  wb_ack,
    output logic                  wb_err,
    input  logic                  fir_ce,
    output logic [NTAPS*CW-1:0]   coeff,
    output logic                  coeff_upd,
    output logic [15:0]           testvec_sel
);
    localparam int SW = DW / 8;
    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int XW = (DW > 16) ? DW : 16;
    localparam logic [CW-1:0] UNITY = CW'(1) << (CW - 2);
    localparam logic [AW-1:0] ADR_CTRL    = AW'(7'h40);
    localparam logic [AW-1:0] ADR_STATUS  = AW'(7'h41);
    localparam logic [AW-1:0] ADR_TESTVEC = AW'(7'h42);
    localparam logic [AW-1:0] ADR_CNT     = AW'(7'h43);
`ifdef FIR_COEF_SYM_EN
    localparam int NADDR = (NTAPS - 1) / 2 + 1;
`else
    localparam int NADDR = NTAPS;
`endif

    typedef enum logic {IDLE, PENDING} state_t;
    state_t state, state_nx;

    logic [CW-1:0] shadow [NTAPS];
    logic [15:0]   commit_cnt;
    logic          copied;

    logic          acc, is_coef, coef_wr, tv_wr, commit_req, resp_err, do_copy;
    logic [DW-1:0] wmask, rd_val, old_ext;
    logic [IW-1:0] tap;
    logic [CW-1:0] coef_new;
    logic [15:0]   tv_new;
`ifdef FIR_COEF_SYM_EN
    logic [IW-1:0] mirror;
    assign mirror = IW'(NTAPS - 1) - tap;
`endif

    // Request decode; a response is registered one cycle after acceptance.
    always_comb begin
        acc        = wb_cyc & wb_stb & ~wb_ack & ~wb_err;
        tap        = wb_adr[IW-1:0];
        is_coef    = wb_adr < AW'(NADDR);
        for (int b = 0; b < SW; b++) wmask[b*8 +: 8] = {8{wb_sel[b]}};
        old_ext    = DW'($signed(shadow[tap]));
        coef_new   = CW'((old_ext & ~wmask) | (wb_wr_dat & wmask));
        tv_new     = 16'((XW'(testvec_sel) & ~XW'(wmask)) | (XW'(wb_wr_dat) & XW'(wmask)));
        resp_err   = 1'b0;
        rd_val     = '0;
        coef_wr    = 1'b0;
        tv_wr      = 1'b0;
        commit_req = 1'b0;
        if (is_coef) begin
            rd_val = old_ext;
            if (wb_we) begin
                if (state == PENDING) resp_err = 1'b1;
                else                  coef_wr  = 1'b1;
            end
        end else begin
            case (wb_adr)
                ADR_CTRL:    commit_req = wb_we & wb_sel[0] & wb_wr_dat[0];
                ADR_STATUS:  begin rd_val = DW'(state == PENDING); resp_err = wb_we; end
                ADR_TESTVEC: begin rd_val = DW'(testvec_sel);      tv_wr    = wb_we; end
                ADR_CNT:     begin rd_val = DW'(commit_cnt);       resp_err = wb_we; end
                default:     resp_err = 1'b1;
            endcase
        end
    end

    // Commit FSM: fir_ce only completes a commit once PENDING is the registered state.
    always_comb begin
        state_nx = state;
        do_copy  = 1'b0;
        case (state)
            IDLE:    if (acc && commit_req) state_nx = PENDING;
            PENDING: if (fir_ce) begin
                state_nx = IDLE;
                do_copy  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack      <= 1'b0;
            wb_err      <= 1'b0;
            wb_rd_dat   <= '0;
            testvec_sel <= '0;
            commit_cnt  <= '0;
            copied      <= 1'b0;
            coeff_upd   <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                shadow[k]          <= (k == NTAPS / 2) ? UNITY : '0;
                coeff[k*CW +: CW]  <= (k == NTAPS / 2) ? UNITY : '0;
            end
        end else begin
            wb_ack    <= acc & ~resp_err;
            wb_err    <= acc & resp_err;
            wb_rd_dat <= (acc && !resp_err && !wb_we) ? rd_val : '0;
            copied    <= do_copy;
            coeff_upd <= copied;
            if (acc && coef_wr) begin
                shadow[tap] <= coef_new;
`ifdef FIR_COEF_SYM_EN
                shadow[mirror] <= coef_new;
`endif
            end
            if (acc && tv_wr) testvec_sel <= tv_new;
            if (do_copy) begin
                for (int k = 0; k < NTAPS; k++) coeff[k*CW +: CW] <= shadow[k];
                commit_cnt <= commit_cnt + 16'd1;
            end
        end
    end
endmodule

// File: doc/fir_coef_bank.md
Name: fir_coef_bank

Overview:
Parametrised, double-buffered FIR coefficient register bank with a Wishbone slave port. Software writes a shadow coefficient set, then requests a commit. The whole set is copied to the active outputs on the next filter sample strobe, so the datapath never sees a half-updated filter. The block sits between the host Wishbone interconnect and the FIR datapath, and adds status, error reporting and a commit counter.

Parameters:
NTAPS, 33, number of coefficients (2..64)
CW, 16, coefficient width in bits, signed two's complement (2..DW)
DW, 16, Wishbone data width (multiple of 8)
AW, 8, Wishbone word address width (>=7)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
wb_adr  in  AW  word address
wb_wr_dat  in  DW  write data
wb_rd_dat  out  DW  read data, valid with wb_ack
wb_we  in  1  1 = write, 0 = read
wb_sel  in  DW/8  byte enables
wb_stb  in  1  strobe
wb_cyc  in  1  cycle
wb_ack  out  1  single-cycle acknowledge
wb_err  out  1  single-cycle error, exclusive with wb_ack
fir_ce  in  1  sample strobe from datapath, commit point
coeff  out  NTAPS*CW  active coefficients, tap k at [k*CW +: CW]
coeff_upd  out  1  one-cycle pulse, the cycle after active set changes
testvec_sel  out  16  test-vector select

Behaviour:
- Register map, word addresses:
  - 0..NTAPS-1: shadow coefficient k, read/write.
  - 0x40 CTRL, write-only: bit0 = commit request (self-clearing). Reads as 0.
  - 0x41 STATUS, read-only: bit0 = pending.
  - 0x42 TESTVEC, read/write.
  - 0x43 COMMIT_CNT, read-only, 16-bit.
  - Any other address: wb_err.
- Accept rule: a request is accepted when wb_cyc & wb_stb & !wb_ack & !wb_err. Exactly one response pulse (ack or err) follows 1 cycle later. Responses are never back to back, so minimum 2 cycles per access.
- Writes honour wb_sel per byte. Bits at or above CW in a coefficient write are ignored.
- Coefficient reads return the shadow value sign-extended to DW.
- wb_err cases; state is unchanged in every case:
  - unmapped address;
  - write to STATUS or COMMIT_CNT;
  - write to a coefficient while pending = 1.
- Commit FSM, states IDLE and PENDING:
  - IDLE -> PENDING on an accepted CTRL write with byte0 enabled and bit0 = 1.
  - PENDING -> IDLE on the first fir_ce seen in a cycle after the transition into PENDING. A commit request and fir_ce in the same cycle do not copy in that cycle.
  - On the PENDING -> IDLE edge: active <= shadow (all taps in one clock), COMMIT_CNT increments (wraps 0xFFFF -> 0), and coeff_upd pulses the following cycle.
  - A CTRL commit request while already PENDING is acked and has no further effect.
- fir_ce while IDLE: no effect.
- Reset (asynchronous, any time including mid-transaction or while PENDING):
  - shadow and active: all taps 0, except tap NTAPS/2 = 2^(CW-2) (unity impulse);
  - testvec_sel = 0, COMMIT_CNT = 0, state IDLE;
  - wb_ack, wb_err, coeff_upd, wb_rd_dat = 0.
  - An in-flight Wishbone access gets no response.

Optional Feature:
FIR_COEF_SYM_EN:
- Defined: symmetric mode.
  - Only taps 0..(NTAPS-1)/2 are addressable.
  - A write to tap k also writes tap NTAPS-1-k.
  - Coefficient addresses above (NTAPS-1)/2 up to NTAPS-1 return wb_err.
- Undefined: every tap is independently addressable, as described under Behaviour.

Test Plan:
- Reset release -> coeff tap16 = 0x4000, all other taps 0, and each of taps 0..32 reads back with ack after 1 cycle. Read 0x41 -> 0. Read 0x43 -> 0.
- Write 0x0005 = 0x1234 with sel = 2'b01 -> tap5 shadow reads 0x0034. The coeff output does not change.
- Write CTRL = 1 -> STATUS = 1. Write to 0x0003 -> wb_err, tap3 unchanged. Pulse fir_ce -> the coeff output changes in one clock, coeff_upd pulses 1 cycle later, STATUS = 0, COMMIT_CNT = 1.
- CTRL write accepted in the same cycle as fir_ce -> no copy. The copy happens on the next fir_ce.
- Read 0x7F and write 0x41 -> wb_err, no ack, and both responses are one-cycle pulses.
- Assert rst while PENDING, mid-read -> ack never asserts, STATUS = 0, coeff reverts to the impulse.
- With FIR_COEF_SYM_EN defined: write tap 2 = 0x0100 -> after commit, taps 2 and 30 = 0x0100. Write tap 20 -> wb_err.
